// File: rtl/pipe_sched_ctrl_if.sv
// Handshake bundle between the ID stage and the pipeline scheduling controller.
// The master drives the decoded ID fields and Flush; the controller drives stall, EX and occupancy.
interface pipe_sched_ctrl_if;
  logic       ID_Valid;
  logic [5:0] ID_OpCode;
  logic [5:0] ID_Func;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic [4:0] ID_Rd;
  logic       Flush;
  logic       ID_Stall;
  logic       EX_Valid;
  logic [2:0] EX_ALUop;
  logic       EX_ALUsrc;
  logic [1:0] EX_FwdA;
  logic [1:0] EX_FwdB;
  logic       MEM_Valid;
  logic       WB_Valid;

  modport master (
    output ID_Valid, ID_OpCode, ID_Func, ID_Rs, ID_Rt, ID_Rd, Flush,
    input  ID_Stall, EX_Valid, EX_ALUop, EX_ALUsrc, EX_FwdA, EX_FwdB, MEM_Valid, WB_Valid
  );

  modport slave (
    input  ID_Valid, ID_OpCode, ID_Func, ID_Rs, ID_Rt, ID_Rd, Flush,
    output ID_Stall, EX_Valid, EX_ALUop, EX_ALUsrc, EX_FwdA, EX_FwdB, MEM_Valid, WB_Valid
  );
endinterface

// File: rtl/pipe_sched_ctrl.sv
// Pipeline scheduler: decodes ID, tracks EX/MEM/WB occupancy and destinations,
// selects operand forwarding at capture, and stalls ID while a multi-cycle SLL holds EX.
module pipe_sched_ctrl #(
  parameter int SHIFT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_sched_ctrl_if.slave bus
);
  localparam int CNT_W = (SHIFT_LAT > 2) ? 2 : 1;

  typedef enum logic {RUN, SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_ex_valid, r_ex_writes, r_mem_valid, r_mem_writes, r_wb_valid, r_wb_writes;
  logic [4:0]       r_ex_dest, r_mem_dest, r_wb_dest;
  logic             w_ex_valid_next, w_ex_writes_next, w_mem_valid_next, w_mem_writes_next;
  logic             w_wb_valid_next, w_wb_writes_next;
  logic [4:0]       w_ex_dest_next, w_mem_dest_next, w_wb_dest_next;
  logic [2:0]       r_aluop, w_aluop_next;
  logic             r_alusrc, w_alusrc_next;
  logic [1:0]       r_fwd_a, r_fwd_b, w_fwd_a_next, w_fwd_b_next;

  logic       w_dec_valid, w_dec_wr_raw, w_dec_writes, w_dec_sll, w_dec_alusrc;
  logic       w_rd_rs, w_rd_rt;
  logic [4:0] w_dec_dest;
  logic [2:0] w_dec_aluop;
  logic [1:0] w_fwd_a, w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] src,
                                         input logic ex_wr, input logic [4:0] ex_dest,
                                         input logic mem_wr, input logic [4:0] mem_dest);
    if (!rd || src == 5'd0)                return 2'b00;
    else if (ex_wr && src == ex_dest)      return 2'b01;
    else if (mem_wr && src == mem_dest)    return 2'b10;
    else                                   return 2'b00;
  endfunction

  always_comb begin
    w_dec_valid  = 1'b0;
    w_dec_wr_raw = 1'b0;
    w_dec_dest   = 5'd0;
    w_dec_sll    = 1'b0;
    w_dec_aluop  = 3'b000;
    w_dec_alusrc = 1'b0;
    w_rd_rs      = 1'b0;
    w_rd_rt      = 1'b0;
    if (bus.ID_Valid) begin
      case (bus.ID_OpCode)
        6'b000011, 6'b001111: begin
          w_dec_valid  = 1'b1;
          w_dec_wr_raw = 1'b1;
          w_dec_dest   = bus.ID_Rt;
          w_rd_rs      = 1'b1;
          w_dec_alusrc = 1'b1;
          w_dec_aluop  = (bus.ID_OpCode == 6'b001111) ? 3'b111 : 3'b000;
        end
        6'b000000: begin
          w_dec_valid = 1'b1;
          w_dec_dest  = bus.ID_Rd;
          w_rd_rs     = 1'b1;
          w_rd_rt     = 1'b1;
          case (bus.ID_Func)
            6'b000011: w_dec_wr_raw = 1'b1;
            6'b000010: begin
              w_dec_wr_raw = 1'b1;
              w_dec_aluop  = 3'b001;
              w_dec_sll    = 1'b1;
            end
            6'b000111: begin
              w_dec_wr_raw = 1'b1;
              w_dec_aluop  = 3'b111;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Register 0 is never a real producer, so it is recorded as a non-writer.
  assign w_dec_writes = w_dec_wr_raw && (w_dec_dest != 5'd0);
  assign w_fwd_a = fwd_sel(w_rd_rs, bus.ID_Rs, r_ex_writes, r_ex_dest, r_mem_writes, r_mem_dest);
  assign w_fwd_b = fwd_sel(w_rd_rt, bus.ID_Rt, r_ex_writes, r_ex_dest, r_mem_writes, r_mem_dest);

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_ex_valid_next   = r_ex_valid;
    w_ex_writes_next  = r_ex_writes;
    w_ex_dest_next    = r_ex_dest;
    w_mem_valid_next  = 1'b0;
    w_mem_writes_next = 1'b0;
    w_mem_dest_next   = 5'd0;
    w_wb_valid_next   = r_mem_valid;
    w_wb_writes_next  = r_mem_writes;
    w_wb_dest_next    = r_mem_dest;
    w_aluop_next      = r_aluop;
    w_alusrc_next     = r_alusrc;
    w_fwd_a_next      = r_fwd_a;
    w_fwd_b_next      = r_fwd_b;
    if (bus.Flush) begin
      if (r_state == RUN) begin
        w_mem_valid_next  = r_ex_valid;
        w_mem_writes_next = r_ex_writes;
        w_mem_dest_next   = r_ex_dest;
      end
      w_ex_valid_next  = 1'b0;
      w_ex_writes_next = 1'b0;
      w_ex_dest_next   = 5'd0;
      w_aluop_next     = 3'b000;
      w_alusrc_next    = 1'b0;
      w_fwd_a_next     = 2'b00;
      w_fwd_b_next     = 2'b00;
      w_state_next     = RUN;
      w_cnt_next       = '0;
    end else if (r_state == RUN) begin
      w_mem_valid_next  = r_ex_valid;
      w_mem_writes_next = r_ex_writes;
      w_mem_dest_next   = r_ex_dest;
      w_ex_valid_next   = w_dec_valid;
      w_ex_writes_next  = w_dec_writes;
      w_ex_dest_next    = w_dec_dest;
      w_aluop_next      = w_dec_aluop;
      w_alusrc_next     = w_dec_alusrc;
      w_fwd_a_next      = w_fwd_a;
      w_fwd_b_next      = w_fwd_b;
      if (w_dec_sll && SHIFT_LAT > 1) begin
        w_state_next = SHIFT;
        w_cnt_next   = CNT_W'(SHIFT_LAT - 1);
      end
    end else begin
      w_cnt_next = r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) w_state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_ex_valid   <= 1'b0;
      r_ex_writes  <= 1'b0;
      r_ex_dest    <= 5'd0;
      r_mem_valid  <= 1'b0;
      r_mem_writes <= 1'b0;
      r_mem_dest   <= 5'd0;
      r_wb_valid   <= 1'b0;
      r_wb_writes  <= 1'b0;
      r_wb_dest    <= 5'd0;
      r_aluop      <= 3'b000;
      r_alusrc     <= 1'b0;
      r_fwd_a      <= 2'b00;
      r_fwd_b      <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_ex_valid   <= w_ex_valid_next;
      r_ex_writes  <= w_ex_writes_next;
      r_ex_dest    <= w_ex_dest_next;
      r_mem_valid  <= w_mem_valid_next;
      r_mem_writes <= w_mem_writes_next;
      r_mem_dest   <= w_mem_dest_next;
      r_wb_valid   <= w_wb_valid_next;
      r_wb_writes  <= w_wb_writes_next;
      r_wb_dest    <= w_wb_dest_next;
      r_aluop      <= w_aluop_next;
      r_alusrc     <= w_alusrc_next;
      r_fwd_a      <= w_fwd_a_next;
      r_fwd_b      <= w_fwd_b_next;
    end
  end

  assign bus.ID_Stall  = (r_state == SHIFT);
  assign bus.EX_Valid  = r_ex_valid;
  assign bus.EX_ALUop  = r_aluop;
  assign bus.EX_ALUsrc = r_alusrc;
  assign bus.EX_FwdA   = r_fwd_a;
  assign bus.EX_FwdB   = r_fwd_b;
  assign bus.MEM_Valid = r_mem_valid;
  assign bus.WB_Valid  = r_wb_valid;
endmodule

// File: tb/tb_pipe_sched_ctrl.sv
// Directed bench for pipe_sched_ctrl: a SHIFT_LAT=2 and a SHIFT_LAT=4 instance share one stimulus stream.
module tb_pipe_sched_ctrl;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pipe_sched_ctrl_if u_if2 ();
  pipe_sched_ctrl_if u_if4 ();

  pipe_sched_ctrl #(.SHIFT_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));
  pipe_sched_ctrl #(.SHIFT_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4));

  assign u_if4.ID_Valid  = u_if2.ID_Valid;
  assign u_if4.ID_OpCode = u_if2.ID_OpCode;
  assign u_if4.ID_Func   = u_if2.ID_Func;
  assign u_if4.ID_Rs     = u_if2.ID_Rs;
  assign u_if4.ID_Rt     = u_if2.ID_Rt;
  assign u_if4.ID_Rd     = u_if2.ID_Rd;
  assign u_if4.Flush     = u_if2.Flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    u_if2.ID_Valid  = v;
    u_if2.ID_OpCode = op;
    u_if2.ID_Func   = fn;
    u_if2.ID_Rs     = rs;
    u_if2.ID_Rt     = rt;
    u_if2.ID_Rd     = rd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if2.Flush = 1'b0;
    put(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    #3;
    chk("rst_ex_valid",  u_if2.EX_Valid, 0);
    chk("rst_mem_valid", u_if2.MEM_Valid, 0);
    chk("rst_wb_valid",  u_if2.WB_Valid, 0);
    chk("rst_aluop",     u_if2.EX_ALUop, 0);
    chk("rst_alusrc",    u_if2.EX_ALUsrc, 0);
    chk("rst_fwd",       {u_if2.EX_FwdA, u_if2.EX_FwdB}, 0);
    chk("rst_stall",     u_if2.ID_Stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI r1 then ADD r2,r1,r1
    put(1'b1, 6'b000011, 6'd0, 5'd0, 5'd1, 5'd0);
    step();
    chk("addi_ex_valid", u_if2.EX_Valid, 1);
    chk("addi_alusrc",   u_if2.EX_ALUsrc, 1);
    chk("addi_fwda",     u_if2.EX_FwdA, 0);
    put(1'b1, 6'b000000, 6'b000011, 5'd1, 5'd1, 5'd2);
    chk("add_id_stall",  u_if2.ID_Stall, 0);
    step();
    chk("add_fwda",      u_if2.EX_FwdA, 2'b01);
    chk("add_fwdb",      u_if2.EX_FwdB, 2'b01);
    chk("add_alusrc",    u_if2.EX_ALUsrc, 0);
    chk("add_mem_valid", u_if2.MEM_Valid, 1);
    chk("add_stall",     u_if2.ID_Stall, 0);

    // ADD r3,r1,r2 (r1 in MEM, r2 in EX), bubble, ANDI r4,r3
    put(1'b1, 6'b000000, 6'b000011, 5'd1, 5'd2, 5'd3);
    step();
    chk("add3_fwda", u_if2.EX_FwdA, 2'b10);
    chk("add3_fwdb", u_if2.EX_FwdB, 2'b01);
    put(1'b0, 6'b000011, 6'd0, 5'd3, 5'd9, 5'd0);
    step();
    chk("bubble_ex_valid", u_if2.EX_Valid, 0);
    put(1'b1, 6'b001111, 6'd0, 5'd3, 5'd4, 5'd0);
    step();
    chk("andi_fwda",      u_if2.EX_FwdA, 2'b10);
    chk("andi_fwdb",      u_if2.EX_FwdB, 2'b00);
    chk("andi_aluop",     u_if2.EX_ALUop, 3'b111);
    chk("andi_alusrc",    u_if2.EX_ALUsrc, 1);
    chk("andi_mem_valid", u_if2.MEM_Valid, 0);
    chk("andi_wb_valid",  u_if2.WB_Valid, 1);

    // SLL r5,r4 then ADD r6,r5,r0 with SHIFT_LAT=2
    put(1'b1, 6'b000000, 6'b000010, 5'd0, 5'd4, 5'd5);
    step();
    chk("sll_aluop",     u_if2.EX_ALUop, 3'b001);
    chk("sll_fwdb",      u_if2.EX_FwdB, 2'b01);
    chk("sll_stall",     u_if2.ID_Stall, 1);
    chk("sll_mem_valid", u_if2.MEM_Valid, 1);
    put(1'b1, 6'b000000, 6'b000011, 5'd5, 5'd0, 5'd6);
    step();
    chk("shift_stall",     u_if2.ID_Stall, 0);
    chk("shift_mem_valid", u_if2.MEM_Valid, 0);
    chk("shift_aluop",     u_if2.EX_ALUop, 3'b001);
    chk("shift_ex_valid",  u_if2.EX_Valid, 1);
    step();
    chk("add6_fwda",      u_if2.EX_FwdA, 2'b01);
    chk("add6_fwdb",      u_if2.EX_FwdB, 2'b00);
    chk("add6_aluop",     u_if2.EX_ALUop, 3'b000);
    chk("add6_mem_valid", u_if2.MEM_Valid, 1);
    chk("add6_stall",     u_if2.ID_Stall, 0);

    // ADDI r0 then ADD r7,r0,r0; unknown opcode
    put(1'b1, 6'b000011, 6'd0, 5'd0, 5'd0, 5'd0);
    step();
    chk("addi0_ex_valid", u_if2.EX_Valid, 1);
    put(1'b1, 6'b000000, 6'b000011, 5'd0, 5'd0, 5'd7);
    step();
    chk("add7_fwd", {u_if2.EX_FwdA, u_if2.EX_FwdB}, 0);
    put(1'b1, 6'b111111, 6'b000011, 5'd7, 5'd7, 5'd8);
    step();
    chk("unk_ex_valid", u_if2.EX_Valid, 0);
    chk("unk_fwd",      {u_if2.EX_FwdA, u_if2.EX_FwdB}, 0);

    // Flush in RUN: prior EX advances to MEM, ID is dropped
    put(1'b1, 6'b000011, 6'd0, 5'd7, 5'd9, 5'd0);
    step();
    put(1'b1, 6'b000000, 6'b000011, 5'd9, 5'd9, 5'd10);
    u_if2.Flush = 1'b1;
    step();
    u_if2.Flush = 1'b0;
    chk("flrun_ex_valid",  u_if2.EX_Valid, 0);
    chk("flrun_mem_valid", u_if2.MEM_Valid, 1);
    chk("flrun_fwd",       {u_if2.EX_FwdA, u_if2.EX_FwdB}, 0);
    chk("flrun_alusrc",    u_if2.EX_ALUsrc, 0);

    // Reset pulse mid-SHIFT, no clock edge in between
    put(1'b1, 6'b000000, 6'b000010, 5'd1, 5'd1, 5'd5);
    step();
    chk("pre_rst_stall4", u_if4.ID_Stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall4",     u_if4.ID_Stall, 0);
    chk("arst_ex_valid4",  u_if4.EX_Valid, 0);
    chk("arst_mem_valid4", u_if4.MEM_Valid, 0);
    chk("arst_wb_valid4",  u_if4.WB_Valid, 0);
    chk("arst_aluop4",     u_if4.EX_ALUop, 0);
    chk("arst_fwd4",       {u_if4.EX_FwdA, u_if4.EX_FwdB}, 0);
    put(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ex_valid4", u_if4.EX_Valid, 0);
    chk("post_rst_stall4",    u_if4.ID_Stall, 0);

    // Flush during SHIFT with SHIFT_LAT=4
    put(1'b1, 6'b000000, 6'b000010, 5'd0, 5'd2, 5'd5);
    step();
    chk("sll4_stall",  u_if4.ID_Stall, 1);
    chk("sll4_aluop",  u_if4.EX_ALUop, 3'b001);
    put(1'b1, 6'b000000, 6'b000011, 5'd5, 5'd0, 5'd6);
    step();
    chk("sll4_stall2",    u_if4.ID_Stall, 1);
    chk("sll4_mem_valid", u_if4.MEM_Valid, 0);
    u_if2.Flush = 1'b1;
    step();
    u_if2.Flush = 1'b0;
    chk("flsh_ex_valid4",  u_if4.EX_Valid, 0);
    chk("flsh_stall4",     u_if4.ID_Stall, 0);
    chk("flsh_mem_valid4", u_if4.MEM_Valid, 0);
    chk("flsh_aluop4",     u_if4.EX_ALUop, 0);
    put(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    step();
    chk("after_flsh_stall4",    u_if4.ID_Stall, 0);
    chk("after_flsh_ex_valid4", u_if4.EX_Valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
